ship_placement_fsm: RTL

- Consumes the ship-count handshake from the decision stage (`ships_decided` plus `player_amount_ships`) of the Battleship game.
- Lets the player place that many ships on a BOARD_W x BOARD_H grid with cursor, rotate and place buttons, and maintains the occupancy bitmap.
- Ship k (k = 1..count) is k cells long.
- Asserts `placement_done` for the downstream attack stage once all ships are placed.

---
 rtl/ship_placement_fsm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ship_placement_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ship_placement_fsm
// Brief    : Battleship ship placement: cursor/rotate/place control with a
//            registered occupancy bitmap; ship k is k cells long.
// Revision : 1.0 - initial release
// ============================================================================
module ship_placement_fsm #(
    parameter int BOARD_W   = 5,
    parameter int BOARD_H   = 5,
    parameter int MAX_SHIPS = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ships_decided,
    input  logic [2:0]                 player_amount_ships,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_rotate,
    input  logic                       btn_place,
    output logic [2:0]                 cursor_x,
    output logic [2:0]                 cursor_y,
    output logic                       orientation,
    output logic [2:0]                 ship_index,
    output logic [2:0]                 ship_count,
    output logic [BOARD_W*BOARD_H-1:0] board,
    output logic                       place_error,
    output logic                       placement_done
);

    localparam int         c_CELLS     = BOARD_W * BOARD_H;
    localparam logic [2:0] c_MAX_X     = 3'(BOARD_W - 1);
    localparam logic [2:0] c_MAX_Y     = 3'(BOARD_H - 1);
    localparam logic [2:0] c_MAX_SHIPS = 3'(MAX_SHIPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLACE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_cx;
    logic [2:0]           r_cy;
    logic                 r_orient;
    logic [2:0]           r_idx;
    logic [2:0]           r_cnt;
    logic [c_CELLS-1:0]   r_board;
    logic                 r_err;
    logic                 r_done;

    logic [c_CELLS-1:0]   w_mask;
    logic                 w_fit;
    logic                 w_legal;
    logic [2:0]           w_clamped;

    // Cells covered by the current ship at the cursor, clipped to the grid.
    always_comb begin
        w_mask = '0;
        for (int yy = 0; yy < BOARD_H; yy++) begin
            for (int xx = 0; xx < BOARD_W; xx++) begin
                if (!r_orient) begin
                    w_mask[yy*BOARD_W + xx] = (yy == int'(r_cy)) &&
                                              (xx >= int'(r_cx)) &&
                                              (xx <  int'(r_cx) + int'(r_idx));
                end else begin
                    w_mask[yy*BOARD_W + xx] = (xx == int'(r_cx)) &&
                                              (yy >= int'(r_cy)) &&
                                              (yy <  int'(r_cy) + int'(r_idx));
                end
            end
        end
    end

    assign w_fit     = r_orient ? (int'(r_cy) + int'(r_idx) <= BOARD_H)
                                : (int'(r_cx) + int'(r_idx) <= BOARD_W);
    assign w_legal   = w_fit && ((w_mask & r_board) == '0);
    assign w_clamped = (player_amount_ships > c_MAX_SHIPS) ? c_MAX_SHIPS
                                                            : player_amount_ships;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cx     <= 3'd0;
            r_cy     <= 3'd0;
            r_orient <= 1'b0;
            r_idx    <= 3'd0;
            r_cnt    <= 3'd0;
            r_board  <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ships_decided && (player_amount_ships != 3'd0)) begin
                        r_cnt   <= w_clamped;
                        r_idx   <= 3'd1;
                        r_state <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    // One action per cycle; the if-chain encodes the priority.
                    if (btn_place) begin
                        if (w_legal) begin
                            r_board <= r_board | w_mask;
                            if (r_idx == r_cnt) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (btn_rotate) begin
                        r_orient <= ~r_orient;
                    end else if (btn_up) begin
                        if (r_cy != 3'd0) r_cy <= r_cy - 3'd1;
                    end else if (btn_down) begin
                        if (r_cy != c_MAX_Y) r_cy <= r_cy + 3'd1;
                    end else if (btn_left) begin
                        if (r_cx != 3'd0) r_cx <= r_cx - 3'd1;
                    end else if (btn_right) begin
                        if (r_cx != c_MAX_X) r_cx <= r_cx + 3'd1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cursor_x       = r_cx;
    assign cursor_y       = r_cy;
    assign orientation    = r_orient;
    assign ship_index     = r_idx;
    assign ship_count     = r_cnt;
    assign board          = r_board;
    assign place_error    = r_err;
    assign placement_done = r_done;

endmodule
`default_nettype wire
